// File: rtl/agusec_range_pipe_if.sv
// Request/result bus for agusec_range_pipe.
// Each channel sends a pointer check in and gets a verdict back.
interface agusec_range_pipe_if #(
    parameter int CH = 2
);
    logic [CH-1:0]    in_vld;
    logic [CH*64-1:0] in_ptr;
    logic [CH-1:0]    in_cin;
    logic [CH-1:0]    chk_en;
    logic [CH-1:0]    out_vld;
    logic [CH-1:0]    out_ok;
    logic [CH-1:0]    out_fault;

    modport master (
        output in_vld, in_ptr, in_cin, chk_en,
        input  out_vld, out_ok, out_fault
    );

    modport slave (
        input  in_vld, in_ptr, in_cin, chk_en,
        output out_vld, out_ok, out_fault
    );
endinterface

// File: rtl/agusec_range_pipe.sv
// Two-stage per-channel pointer bounds checker.
// Also keeps fault status: sticky flags, a saturating counter and the first faulting channel.
module agusec_range_pipe #(
    parameter int CH           = 2,
    parameter int CNT_W        = 16,
    parameter int MAX_EXP_PASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    agusec_range_pipe_if.slave bus,
    input  logic               stall,
    input  logic               clr,
    output logic [CH-1:0]      fault_sticky,
    output logic [CNT_W-1:0]   fault_cnt,
    output logic [2:0]         first_ch,
    output logic               first_vld
);
    // Bounds metadata sits above the 40-bit address window ptr[43:4].
    localparam int EXP_LSB    = 59;
    localparam int HI_LSB     = 52;
    localparam int LOW_LSB    = 45;
    localparam int ON_LOW_BIT = 44;

    logic [CH-1:0]      s1_vld_q, s1_vld_d;
    logic [CH-1:0]      s1_cin_q, s1_cin_d;
    logic [CH-1:0]      s1_en_q, s1_en_d;
    logic [CH-1:0]      s1_on_low_q, s1_on_low_d;
    logic [CH-1:0][6:0] s1_low_q, s1_low_d;
    logic [CH-1:0][6:0] s1_hi_q, s1_hi_d;
    logic [CH-1:0][4:0] s1_exp_q, s1_exp_d;
    logic [CH-1:0][7:0] s1_bits_q, s1_bits_d;
    logic [CH-1:0]      out_vld_q, out_vld_d;
    logic [CH-1:0]      out_ok_q, out_ok_d;
    logic [CH-1:0]      sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         first_ch_q, first_ch_d;
    logic               first_vld_q, first_vld_d;

    logic [CH-1:0][7:0] bits_c;
    logic [CH-1:0][6:0] low_c;
    logic [CH-1:0][6:0] hi_c;
    logic [CH-1:0][4:0] exp_c;
    logic [CH-1:0]      on_low_c;
    logic [CH-1:0]      ok_c;
    logic [CH-1:0]      unused_ptr;

    logic [CH-1:0]      new_fault;
    logic [3:0]         pop;
    logic [2:0]         low_idx;
    logic [CNT_W+3:0]   cnt_sum;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [63:0] ptr;
        logic [7:0]  lo;
        logic [7:0]  hi8;
        logic        diff;
        logic        above_lo;
        logic        below_hi;
        logic        forced;

        assign ptr           = bus.in_ptr[i*64 +: 64];
        assign exp_c[i]      = ptr[EXP_LSB +: 5];
        assign hi_c[i]       = ptr[HI_LSB +: 7];
        assign low_c[i]      = ptr[LOW_LSB +: 7];
        assign on_low_c[i]   = ptr[ON_LOW_BIT];
        assign bits_c[i]     = 8'(ptr[43:4] >> exp_c[i]);
        assign unused_ptr[i] = ^ptr[3:0];

        // A wrapped region (hi below low) relaxes whichever bound on_low selects.
        assign lo       = {s1_low_q[i], 1'b0};
        assign hi8      = {s1_hi_q[i], 1'b1};
        assign diff     = s1_hi_q[i] < s1_low_q[i];
        assign above_lo = (s1_bits_q[i] >= lo) | (diff & ~s1_on_low_q[i]);
        assign below_hi = (s1_bits_q[i] <= hi8) | (diff & s1_on_low_q[i]);
        assign forced   = ~s1_en_q[i] | ((MAX_EXP_PASS == 1) && (s1_exp_q[i] == 5'h1f));
        assign ok_c[i]  = s1_cin_q[i] & (forced | (above_lo & below_hi));
    end

    // Next-state for both pipeline stages and fault bookkeeping; stall freezes all of it.
    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_cin_d    = s1_cin_q;
        s1_en_d     = s1_en_q;
        s1_on_low_d = s1_on_low_q;
        s1_low_d    = s1_low_q;
        s1_hi_d     = s1_hi_q;
        s1_exp_d    = s1_exp_q;
        s1_bits_d   = s1_bits_q;
        out_vld_d   = out_vld_q;
        out_ok_d    = out_ok_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        first_ch_d  = first_ch_q;
        first_vld_d = first_vld_q;
        new_fault   = '0;
        pop         = '0;
        low_idx     = '0;
        cnt_sum     = '0;

        if (!stall) begin
            s1_vld_d    = bus.in_vld;
            s1_cin_d    = bus.in_cin;
            s1_en_d     = bus.chk_en;
            s1_on_low_d = on_low_c;
            s1_low_d    = low_c;
            s1_hi_d     = hi_c;
            s1_exp_d    = exp_c;
            s1_bits_d   = bits_c;
            out_vld_d   = s1_vld_q;
            out_ok_d    = s1_vld_q & ok_c;
            new_fault   = s1_vld_q & ~ok_c;

            for (int i = 0; i < CH; i++) begin
                pop = pop + 4'(new_fault[i]);
            end
            for (int i = CH - 1; i >= 0; i--) begin
                if (new_fault[i]) low_idx = 3'(i);
            end

            // Faults arriving alongside clr survive it: clear first, then accumulate.
            sticky_d = (clr ? '0 : sticky_q) | new_fault;
            cnt_sum  = (clr ? '0 : {4'b0, cnt_q}) + {{CNT_W{1'b0}}, pop};
            cnt_d    = (|cnt_sum[CNT_W+3:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];

            if (clr) begin
                first_vld_d = 1'b0;
                first_ch_d  = '0;
            end
            if ((clr || !first_vld_q) && (|new_fault)) begin
                first_vld_d = 1'b1;
                first_ch_d  = low_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= '0;
            s1_cin_q    <= '0;
            s1_en_q     <= '0;
            s1_on_low_q <= '0;
            s1_low_q    <= '0;
            s1_hi_q     <= '0;
            s1_exp_q    <= '0;
            s1_bits_q   <= '0;
            out_vld_q   <= '0;
            out_ok_q    <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            first_ch_q  <= '0;
            first_vld_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_cin_q    <= s1_cin_d;
            s1_en_q     <= s1_en_d;
            s1_on_low_q <= s1_on_low_d;
            s1_low_q    <= s1_low_d;
            s1_hi_q     <= s1_hi_d;
            s1_exp_q    <= s1_exp_d;
            s1_bits_q   <= s1_bits_d;
            out_vld_q   <= out_vld_d;
            out_ok_q    <= out_ok_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            first_ch_q  <= first_ch_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign bus.out_vld   = out_vld_q;
    assign bus.out_ok    = out_ok_q;
    assign bus.out_fault = out_vld_q & ~out_ok_q;
    assign fault_sticky  = sticky_q;
    assign fault_cnt     = cnt_q;
    assign first_ch      = first_ch_q;
    assign first_vld     = first_vld_q;
endmodule

// File: doc/agusec_range_pipe.md
AGUSEC_RANGE_PIPE -- requirements
Module: agusec_range_pipe

Interface
REQ-001 Parameter CH, default 2, number of independent check channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of saturating fault counter.
REQ-003 Parameter MAX_EXP_PASS, default 1, when 1 a pointer with exp==5'h1f always passes.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_vld  in  CH  per-channel request valid.
REQ-008 in_ptr  in  CH*64  per-channel pointer; fields per `ptr_exp, `ptr_hi, `ptr_low, `ptr_on_low; address window ptr[43:4].
REQ-009 in_cin  in  CH  per-channel incoming security qualifier.
REQ-010 chk_en  in  CH  per-channel enable; 0 forces pass.
REQ-011 stall  in  1  freezes the whole pipeline.
REQ-012 clr  in  1  clears sticky status and counter.
REQ-013 out_vld  out  CH  result valid.
REQ-014 out_ok  out  CH  access permitted (cout_secq).
REQ-015 out_fault  out  CH  out_vld & ~out_ok.
REQ-016 fault_sticky  out  CH  per-channel sticky fault flag.
REQ-017 fault_cnt  out  CNT_W  saturating count of faulting results.
REQ-018 first_ch  out  3  channel index of first fault since last clr/reset; first_vld  out  1  qualifies it.

Function
REQ-019 Stage 1 (S1) SHALL register vld, cin, chk_en, low, hi, on_low, exp, and bits[7:0] = (ptr[43:4] >> exp)[7:0], zero-filled above bit 39.
REQ-020 Stage 2 (S2) SHALL register out_* from S1; latency in_vld -> out_vld is exactly 2 un-stalled cycles.
REQ-021 S2: lo = {low,1'b0}, hi8 = {hi,1'b1}, diff = (hi < low) unsigned 7-bit.
REQ-022 S2: ok = cin & (bits>=lo | (diff & ~on_low)) & (bits<=hi8 | (diff & on_low)), unsigned 8-bit compares.
REQ-023 ok SHALL be forced to cin when chk_en==0, or when exp==5'h1f and MAX_EXP_PASS==1.
REQ-024 When stall==1, S1 and S2 registers, sticky, counter and first_ch SHALL hold; inputs are dropped; out_vld holds its value but SHALL NOT re-count faults.
REQ-025 A channel with in_vld==0 SHALL propagate out_vld==0 and out_ok==0.
REQ-026 fault_sticky[i] SHALL set on any cycle out_fault[i] is newly produced (un-stalled S2 update) and hold until clr.
REQ-027 fault_cnt SHALL add popcount of newly produced faults per cycle, saturating at all-ones, never wrapping.
REQ-028 first_ch SHALL capture lowest-index faulting channel when first_vld==0; first_vld then sets and holds until clr.
REQ-029 clr SHALL zero sticky, counter, first_vld in the next cycle; same-cycle new faults are counted after the clear (result = new faults only).
REQ-030 clr SHALL NOT affect pipeline data registers.

Reset
REQ-031 While rst_n==0 all outputs and all registers SHALL be 0 asynchronously; reset mid-operation discards in-flight requests.
REQ-032 First valid result after rst_n deasserts SHALL appear 2 cycles after its in_vld.

Verification
REQ-033 exp=0, ptr[11:4]=0x40, low=0x10, hi=0x30, on_low=0, cin=1, chk_en=1 -> 2 cycles later out_vld=1, out_ok=1, fault_cnt=0.
REQ-034 Same but ptr[11:4]=0x70 -> out_fault=1, fault_sticky[0]=1, fault_cnt=1, first_ch=0, first_vld=1.
REQ-035 Wrap: low=0x30, hi=0x05, on_low=1, ptr[11:4]=0x70 -> out_ok=1; same with on_low=0 and ptr[11:4]=0x20 -> out_ok=0.
REQ-036 exp=5'h1f with out-of-range fields, MAX_EXP_PASS=1 -> out_ok=cin; chk_en=0 with out-of-range -> out_ok=cin.
REQ-037 CNT_W=2, five faulting results -> fault_cnt=3; assert clr with 2 simultaneous channel faults -> fault_cnt=2 next cycle.
REQ-038 stall=1 for 3 cycles mid-flight -> outputs frozen, fault_cnt unchanged; rst_n pulse low mid-flight -> all outputs 0, no result emerges.
